// File: rtl/clk_div_by3_pkg.sv
// Shared types and constants for the divide-by-three clock generator.
package clk_div_by3_pkg;

    localparam logic [1:0] DIV_MAX = 2'd2;

    typedef logic [1:0] phase_t;

    // Wraps to zero from DIV_MAX or from any out-of-range upset value.
    function automatic phase_t next_phase(input phase_t cur);
        return (cur >= DIV_MAX) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/negedge_retime.sv
// Single-bit falling-edge flop with asynchronous active-low clear.
module negedge_retime (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) q <= 1'b0;
        else       q <= d;
    end

endmodule

// File: rtl/clk_div_by3.sv
// Divide-by-three clock generator: phase counter, 33.3 % and 50 % duty outputs.
module clk_div_by3
    import clk_div_by3_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    output logic [1:0] q,
    output logic       q33dot3,
    output logic       q50
);

    logic q33_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q       <= 2'd0;
            q33dot3 <= 1'b0;
        end else begin
            q       <= next_phase(q);
            q33dot3 <= (q == DIV_MAX);
        end
    end

    negedge_retime u_retime (
        .clk  (clk),
        .rstn (rstn),
        .d    (q33dot3),
        .q    (q33_n)
    );

    // Half-cycle extension of the one-cycle pulse gives the 1.5-period high time.
    assign q50 = q33dot3 | q33_n;

    a_no_phase3 : assert property (@(posedge clk) disable iff (!rstn) q != 2'd3);
    a_reset_val : assert property (@(posedge clk) !rstn |-> (q == 2'd0 && !q33dot3 && !q50));

endmodule

// File: tb/tb_clk_div_by3.sv
// Self-checking bench for clk_div_by3 against a cycle-count reference model.
`timescale 1ns/1ps
module tb_clk_div_by3;

    logic       clk;
    logic       rstn;
    logic [1:0] q;
    logic       q33dot3;
    logic       q50;

    int n_checks  = 0;
    int n_fail    = 0;
    int k         = 0;   // posedges sampled with rstn high since last release
    int exp_wraps = 0;
    int rises     = 0;
    realtime t_q50_rise = 0.0;
    realtime t_q33_rise = 0.0;

    clk_div_by3 dut (
        .clk     (clk),
        .rstn    (rstn),
        .q       (q),
        .q33dot3 (q33dot3),
        .q50     (q50)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: outputs follow directly from the posedge count since release.
    function automatic int m_q(input int n);
        return n % 3;
    endfunction
    function automatic int m_q33(input int n);
        return (n >= 3 && n % 3 == 0) ? 1 : 0;
    endfunction
    function automatic int m_q50_after_pos(input int n);
        return (n >= 3 && (n % 3 == 0 || n % 3 == 1)) ? 1 : 0;
    endfunction
    function automatic int m_q50_after_neg(input int n);
        return (n >= 3 && n % 3 == 0) ? 1 : 0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_q"},   int'(q),       0);
        check({tag, "_q33"}, int'(q33dot3), 0);
        check({tag, "_q50"}, int'(q50),     0);
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        if (m_q33(k) == 1) exp_wraps++;
        #1;
        check("q_pos",   int'(q),       m_q(k));
        check("q33_pos", int'(q33dot3), m_q33(k));
        check("q50_pos", int'(q50),     m_q50_after_pos(k));
        @(negedge clk);
        #1;
        check("q_neg",   int'(q),       m_q(k));
        check("q33_neg", int'(q33dot3), m_q33(k));
        check("q50_neg", int'(q50),     m_q50_after_neg(k));
    endtask

    task automatic async_reset(input int off);
        @(posedge clk);
        k++;
        if (m_q33(k) == 1) exp_wraps++;
        #1;
        check("q_pre_rst",   int'(q),   m_q(k));
        check("q50_pre_rst", int'(q50), m_q50_after_pos(k));
        #(off);
        rstn = 1'b0;
        #0.1;
        check_zero("rst_async");
        @(negedge clk);
        #1;
        check_zero("rst_hold_neg");
        @(posedge clk);
        #1;
        check_zero("rst_hold_pos");
        @(negedge clk);
        #2;
        rstn = 1'b1;
        k = 0;
    endtask

    always @(posedge q33dot3) begin
        rises++;
        t_q33_rise = $realtime;
    end

    always @(negedge q33dot3) begin
        if (rstn) check("q33_width", int'($realtime - t_q33_rise), 10);
    end

    always @(posedge q50) t_q50_rise = $realtime;

    always @(negedge q50) begin
        if (rstn) check("q50_width", int'($realtime - t_q50_rise), 15);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;

        // Reset hold for three cycles.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("rst_init_pos");
            @(negedge clk);
            #1;
            check_zero("rst_init_neg");
        end
        #1;
        rstn = 1'b1;
        k = 0;

        // First six edges after release: 1,2,0,1,2,0.
        repeat (6) step();

        // Steady-state duty cycles are checked by the width monitors.
        repeat (10) step();

        // Mid-cycle reset while q50 is high (q just wrapped to 0).
        while ((k + 1) % 3 != 0) step();
        async_reset(2);
        repeat (7) step();

        // Mid-cycle reset while q==2.
        while ((k + 1) % 3 != 2) step();
        async_reset(1);
        repeat (4) step();

        // Randomized run lengths interleaved with asynchronous resets.
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(2, 40)) step();
            async_reset($urandom_range(1, 3));
        end

        repeat (300) step();

        check("q33_rises_vs_wraps", rises, exp_wraps);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
